// File: rtl/sram1rw_gen_pkg.sv
// Shared types and constants for the sram1rw_gen single-port SRAM model.
// SRAM1RW_GEN_OUTREG_EN selects the 2-cycle read latency variant.
package sram1rw_gen_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } clr_state_e;

`ifdef SRAM1RW_GEN_OUTREG_EN
  localparam int unsigned RD_LAT = 2;
`else
  localparam int unsigned RD_LAT = 1;
`endif

endpackage

// File: rtl/sram1rw_gen_clr.sv
// Post-reset clear sequencer: walks every address once after RST drops,
// issuing a clear write per cycle and holding BUSY until the last word lands.
module sram1rw_gen_clr
  import sram1rw_gen_pkg::*;
#(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_clr_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_busy;

  // Next-state logic; RESET already writes address 0 on the first edge with RST low.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = r_cnt + 1'b1;
      end
      ST_CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_READY;
          w_cnt_nxt   = r_cnt;
        end else begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
        w_cnt_nxt   = r_cnt;
      end
      default: begin
        w_state_nxt = ST_RESET;
        w_cnt_nxt   = '0;
      end
    endcase
    if (i_rst) begin
      w_state_nxt = ST_RESET;
      w_cnt_nxt   = '0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // State, counter and BUSY registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != ST_READY);
    end
  end

  assign o_busy     = r_busy;
  assign o_clr_addr = r_cnt;
  assign o_clr_we   = r_busy & ~i_rst;

endmodule

// File: rtl/sram1rw_gen.sv
// Parametrised 1RW SRAM model with bit-masked writes, post-reset clear and a
// read-valid strobe. Define SRAM1RW_GEN_OUTREG_EN for an extra O/VLD pipeline stage.
module sram1rw_gen
  import sram1rw_gen_pkg::*;
#(
  parameter int unsigned       DEPTH   = 128,
  parameter int unsigned       WIDTH   = 14,
  parameter int unsigned       ADDR_W  = $clog2(DEPTH),
  parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
  input  logic              CE,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A,
  input  logic              CSB,
  input  logic              WEB,
  input  logic              OEB,
  input  logic [WIDTH-1:0]  I,
  input  logic [WIDTH-1:0]  BM,
  output logic [WIDTH-1:0]  O,
  output logic              VLD,
  output logic              BUSY
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old_w,
                                               input logic [WIDTH-1:0] new_w,
                                               input logic [WIDTH-1:0] mask);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_busy;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_clr_we;
  logic              w_re;
  logic              w_we;
  logic              w_addr_ok;
  logic [WIDTH-1:0]  r_dout;
  logic              r_vld;

  sram1rw_gen_clr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr (
    .i_clk      (CE),
    .i_rst      (RST),
    .o_busy     (w_busy),
    .o_clr_addr (w_clr_addr),
    .o_clr_we   (w_clr_we)
  );

  assign w_re      = ~CSB & ~OEB & ~w_busy;
  assign w_we      = ~CSB & ~WEB & ~w_busy;
  assign w_addr_ok = ({1'b0, A} < DEPTH_L);

  // Array write port; the clear sequencer only runs while host access is blocked.
  always_ff @(posedge CE) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= CLR_VAL;
    end else if (w_we && w_addr_ok) begin
      r_mem[A] <= f_merge(r_mem[A], I, BM);
    end
  end

  // Read port: sampling the pre-write word gives read-first behaviour.
  always_ff @(posedge CE) begin
    if (RST) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= w_re;
      if (w_re) begin
        r_dout <= w_addr_ok ? r_mem[A] : {WIDTH{1'bx}};
      end
    end
  end

`ifdef SRAM1RW_GEN_OUTREG_EN
  logic [WIDTH-1:0] r_dout_q;
  logic             r_vld_q;

  // Optional output pipeline stage.
  always_ff @(posedge CE) begin
    if (RST) begin
      r_dout_q <= '0;
      r_vld_q  <= 1'b0;
    end else begin
      r_dout_q <= r_dout;
      r_vld_q  <= r_vld;
    end
  end

  assign O   = r_dout_q;
  assign VLD = r_vld_q;
`else
  assign O   = r_dout;
  assign VLD = r_vld;
`endif

  assign BUSY = w_busy;

endmodule

// File: tb/tb_sram1rw_gen.sv
// Directed, table-driven bench for sram1rw_gen (DEPTH=128, WIDTH=14).
module tb_sram1rw_gen;
  import sram1rw_gen_pkg::*;

  localparam int DEPTH  = 128;
  localparam int WIDTH  = 14;
  localparam int ADDR_W = 7;

  logic              CE;
  logic              RST;
  logic [ADDR_W-1:0] A;
  logic              CSB;
  logic              WEB;
  logic              OEB;
  logic [WIDTH-1:0]  I;
  logic [WIDTH-1:0]  BM;
  logic [WIDTH-1:0]  O;
  logic              VLD;
  logic              BUSY;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic              do_wr;
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  din;
    logic [WIDTH-1:0]  bm;
    logic [WIDTH-1:0]  exp;
  } vec_t;

  vec_t vecs [8];

  sram1rw_gen #(
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .CLR_VAL (14'h0000)
  ) dut (
    .CE   (CE),
    .RST  (RST),
    .A    (A),
    .CSB  (CSB),
    .WEB  (WEB),
    .OEB  (OEB),
    .I    (I),
    .BM   (BM),
    .O    (O),
    .VLD  (VLD),
    .BUSY (BUSY)
  );

  initial CE = 1'b0;
  always #5 CE = ~CE;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CE);
    @(negedge CE);
  endtask

  task automatic idle;
    CSB = 1'b1;
    WEB = 1'b1;
    OEB = 1'b1;
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] m);
    A = a; I = d; BM = m;
    CSB = 1'b0; WEB = 1'b0; OEB = 1'b1;
    step();
    idle();
  endtask

  task automatic read_check(input string name, input logic [ADDR_W-1:0] a,
                            input logic [WIDTH-1:0] exp);
    A = a;
    CSB = 1'b0; WEB = 1'b1; OEB = 1'b0;
    step();
    idle();
    repeat (RD_LAT - 1) step();
    chk({name, "_vld"}, 32'(VLD), 32'd1);
    chk({name, "_o"}, 32'(O), 32'(exp));
    step();
    chk({name, "_vld_drop"}, 32'(VLD), 32'd0);
    chk({name, "_hold"}, 32'(O), 32'(exp));
  endtask

  // Counts negedge samples with BUSY high, bounded; also flags any VLD seen meanwhile.
  task automatic count_busy(output int n, output logic vld_seen);
    n = 0;
    vld_seen = 1'b0;
    for (int k = 0; k < 1000 && BUSY; k++) begin
      n++;
      if (VLD) vld_seen = 1'b1;
      step();
    end
  endtask

  int   n_busy;
  logic vseen;
  logic [WIDTH-1:0] b2b_exp [3];
  logic [ADDR_W-1:0] b2b_adr [3];

  initial begin
    vecs[0] = '{1'b1, 7'd5,   14'h3FFF, 14'h3FFF, 14'h3FFF};
    vecs[1] = '{1'b1, 7'd5,   14'h0000, 14'h00FF, 14'h3F00};
    vecs[2] = '{1'b1, 7'd5,   14'h1234, 14'h0000, 14'h3F00};
    vecs[3] = '{1'b1, 7'd9,   14'h0123, 14'h3FFF, 14'h0123};
    vecs[4] = '{1'b1, 7'd127, 14'h2AAA, 14'h0F0F, 14'h0A0A};
    vecs[5] = '{1'b1, 7'd0,   14'h1555, 14'h3FFF, 14'h1555};
    vecs[6] = '{1'b0, 7'd64,  14'h3FFF, 14'h3FFF, 14'h0000};
    vecs[7] = '{1'b1, 7'd127, 14'h3FFF, 14'h3000, 14'h3A0A};

    RST = 1'b1;
    A = '0; I = '0; BM = '0;
    idle();
    @(negedge CE);
    step();
    chk("rst_o", 32'(O), 32'd0);
    chk("rst_vld", 32'(VLD), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd1);

    // Host write and read held active through the whole clear must be ignored.
    A = 7'd3; I = 14'h2AAA; BM = 14'h3FFF;
    CSB = 1'b0; WEB = 1'b0; OEB = 1'b0;
    RST = 1'b0;
    count_busy(n_busy, vseen);
    idle();
    chk("busy_len", 32'(n_busy), 32'd128);
    chk("vld_while_busy", 32'(vseen), 32'd0);
    read_check("busy_wr_dropped", 7'd3, 14'h0000);
    read_check("clr_a0", 7'd0, 14'h0000);
    read_check("clr_a64", 7'd64, 14'h0000);
    read_check("clr_a127", 7'd127, 14'h0000);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].do_wr) write(vecs[v].a, vecs[v].din, vecs[v].bm);
      read_check($sformatf("vec%0d", v), vecs[v].a, vecs[v].exp);
    end

    // Same-cycle read and write: read-first, then the write is visible.
    A = 7'd9; I = 14'h1111; BM = 14'h3FFF;
    CSB = 1'b0; WEB = 1'b0; OEB = 1'b0;
    step();
    idle();
    repeat (RD_LAT - 1) step();
    chk("rw_same_vld", 32'(VLD), 32'd1);
    chk("rw_same_old", 32'(O), 32'h0123);
    read_check("rw_same_new", 7'd9, 14'h1111);

    // Back-to-back reads keep VLD high continuously.
    b2b_adr[0] = 7'd5;  b2b_exp[0] = 14'h3F00;
    b2b_adr[1] = 7'd9;  b2b_exp[1] = 14'h1111;
    b2b_adr[2] = 7'd0;  b2b_exp[2] = 14'h1555;
    for (int k = 0; k < 3 + int'(RD_LAT) - 1; k++) begin
      if (k < 3) begin
        A = b2b_adr[k];
        CSB = 1'b0; WEB = 1'b1; OEB = 1'b0;
      end else begin
        idle();
      end
      step();
      if (k >= int'(RD_LAT) - 1) begin
        chk($sformatf("b2b%0d_vld", k), 32'(VLD), 32'd1);
        chk($sformatf("b2b%0d_o", k), 32'(O), 32'(b2b_exp[k - (int'(RD_LAT) - 1)]));
      end
    end
    idle();
    step();
    chk("b2b_end_vld", 32'(VLD), 32'd0);

    // Reset in the middle of a clear restarts the full sweep from address 0.
    write(7'd39, 14'h3FFF, 14'h3FFF);
    write(7'd100, 14'h3FFF, 14'h3FFF);
    read_check("pre_a100", 7'd100, 14'h3FFF);
    RST = 1'b1;
    step();
    RST = 1'b0;
    repeat (40) step();
    chk("mid_busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    step();
    chk("rerst_busy", 32'(BUSY), 32'd1);
    chk("rerst_o", 32'(O), 32'd0);
    chk("rerst_vld", 32'(VLD), 32'd0);
    RST = 1'b0;
    count_busy(n_busy, vseen);
    chk("busy_len_restart", 32'(n_busy), 32'd128);
    read_check("restart_a39", 7'd39, 14'h0000);
    read_check("restart_a100", 7'd100, 14'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
